// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words
// and writes them to consecutive addresses, holding the CPU until a load completes.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, FIN} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   remaining_reg, remaining_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [1:0]        byte_cnt_reg, byte_cnt_next;
  logic [31:0]       word_reg, word_next;
  logic              hold_reg, hold_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      addr_reg      <= '0;
      byte_cnt_reg  <= '0;
      word_reg      <= '0;
      hold_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      addr_reg      <= addr_next;
      byte_cnt_reg  <= byte_cnt_next;
      word_reg      <= word_next;
      hold_reg      <= hold_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    addr_next      = addr_reg;
    byte_cnt_next  = byte_cnt_reg;
    word_next      = word_reg;
    hold_next      = hold_reg;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          remaining_next = word_count;
          addr_next      = '0;
          byte_cnt_next  = '0;
          hold_next      = 1'b1;
          state_next     = (word_count == '0) ? FIN : RECV;
        end
      end
      RECV: begin
        if (abort) begin
          byte_cnt_next = '0;
          state_next    = IDLE;
        end else if (rx_valid) begin
          // First byte of a word lands in the MSB lane.
          case (byte_cnt_reg)
            2'd0:    word_next[31:24] = rx_data;
            2'd1:    word_next[23:16] = rx_data;
            2'd2:    word_next[15:8]  = rx_data;
            default: word_next[7:0]   = rx_data;
          endcase
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3)
            state_next = WRITE;
        end
      end
      WRITE: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          addr_next      = addr_reg + 1'b1;
          remaining_next = remaining_reg - 1'b1;
          state_next     = (remaining_reg == 1) ? FIN : RECV;
        end
      end
      default: begin
        hold_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign rx_ready = (state_reg == RECV);
  assign im_we    = (state_reg == WRITE);
  assign busy     = (state_reg == RECV) || (state_reg == WRITE);
  assign done     = (state_reg == FIN);
  assign cpu_hold = hold_reg;
  assign im_addr  = addr_reg;
  assign im_wdata = word_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes come from a word-level model
// of the byte stream; a negedge monitor pops and compares each write and done.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              abort;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .abort(abort), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t        exp_wr[$];
  bit         exp_done[$];
  logic [7:0] stream[$];
  int         total = 0;
  int         bad   = 0;
  wr_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe and done pulse must match a queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (im_we) begin
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", im_addr, im_wdata);
        end else begin
          mon_e = exp_wr.pop_front();
          check("wr_addr", im_addr, mon_e.addr);
          check("wr_data", im_wdata, mon_e.data);
          $display("write addr=%0h data=%08h", im_addr, im_wdata);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: done=1, no done expected");
        end else begin
          void'(exp_done.pop_front());
          check("done_hold", cpu_hold, 1);
          $display("done pulse");
        end
      end
    end
  end

  // Reference model: word i is bytes 4i..4i+3 MSB-first, at address i mod DEPTH.
  task automatic expect_words(input int n);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = ADDR_W'(i % DEPTH);
      e.data = {stream[4*i], stream[4*i+1], stream[4*i+2], stream[4*i+3]};
      exp_wr.push_back(e);
    end
  endtask

  task automatic random_stream(input int nbytes);
    stream.delete();
    for (int i = 0; i < nbytes; i++) stream.push_back(8'($urandom_range(255)));
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    word_count = (ADDR_W+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk); #1;
        ok = 1;
      end
    end
    rx_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL byte_accept_timeout: rx_ready stayed 0, required 1");
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_stream(input int nbytes, input int maxgap);
    for (int i = 0; i < nbytes; i++) begin
      send_byte(stream[i]);
      idle_cycles($urandom_range(maxgap));
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!busy && !done) ok = 1;
    end
    #1;
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s_timeout: loader never returned idle, required idle", name);
    end
  endtask

  initial begin
    int n;
    bit ok;
    reset = 1'b1; start = 1'b0; word_count = '0; abort = 1'b0;
    rx_data = '0; rx_valid = 1'b0;
    #1;
    check("rst_rx_ready", rx_ready, 0);
    check("rst_im_we",    im_we, 0);
    check("rst_im_addr",  im_addr, 0);
    check("rst_im_wdata", im_wdata, 0);
    check("rst_busy",     busy, 0);
    check("rst_done",     done, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    idle_cycles(2);
    @(negedge clk); reset = 1'b0;
    idle_cycles(1);
    check("idle_hold_after_reset", cpu_hold, 1);

    // Directed two-word load, gap-free.
    stream = '{8'h8C, 8'h22, 8'h00, 8'h04, 8'hAC, 8'h22, 8'h00, 8'h08};
    expect_words(2); exp_done.push_back(1);
    do_start(2);
    send_stream(8, 0);
    wait_idle("load2");
    check("hold_after_load2", cpu_hold, 0);
    $display("load words=2 gapfree");

    // Same program with a 3-cycle rx_valid gap mid-word.
    expect_words(2); exp_done.push_back(1);
    do_start(2);
    for (int i = 0; i < 8; i++) begin
      send_byte(stream[i]);
      if (i == 1) idle_cycles(3);
    end
    wait_idle("load2gap");
    check("hold_after_load2gap", cpu_hold, 0);
    $display("load words=2 with gap");

    // Zero-word load: done the cycle after start, no writes.
    exp_done.push_back(1);
    do_start(0);
    check("zero_done_latency", done, 1);
    wait_idle("load0");
    check("hold_after_load0", cpu_hold, 0);
    $display("load words=0");

    // Abort after 2 bytes of word 1: only word 0 written, no done, hold stays 1.
    random_stream(12);
    expect_words(1);
    do_start(3);
    send_stream(6, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    wait_idle("abort");
    check("abort_hold", cpu_hold, 1);
    check("abort_no_done", exp_done.size(), 0);
    $display("abort after 6 bytes");

    // abort together with start in IDLE: start ignored.
    abort = 1'b1; start = 1'b1; word_count = 1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    check("abort_start_busy", busy, 0);
    check("abort_start_done", done, 0);
    $display("abort with start in idle");

    // Following load restarts at address 0.
    random_stream(4);
    expect_words(1); exp_done.push_back(1);
    do_start(1);
    send_stream(4, 2);
    wait_idle("after_abort");
    check("hold_after_reload", cpu_hold, 0);
    $display("reload words=1");

    // Randomized loads with a spurious start issued mid-load.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 6);
      random_stream(4*n);
      expect_words(n); exp_done.push_back(1);
      do_start(n);
      start = 1'b1; word_count = 1;
      @(posedge clk); #1;
      start = 1'b0;
      send_stream(4*n, 3);
      wait_idle("rand");
      check("rand_hold", cpu_hold, 0);
      check("rand_wr_drained", exp_wr.size(), 0);
      $display("random load words=%0d", n);
    end

    // More words than memory depth: addresses wrap and overwrite.
    n = DEPTH + 2;
    random_stream(4*n);
    expect_words(n); exp_done.push_back(1);
    do_start(n);
    send_stream(4*n, 0);
    wait_idle("wrap");
    check("wrap_hold", cpu_hold, 0);
    $display("wrap load words=%0d", n);

    // Reset asserted while a write strobe is high.
    random_stream(12);
    expect_words(1);
    do_start(3);
    send_stream(4, 0);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (im_we) ok = 1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL midwrite_timeout: im_we never rose, required 1");
    end
    #2 reset = 1'b1;
    #1;
    check("midrst_im_we",    im_we, 0);
    check("midrst_rx_ready", rx_ready, 0);
    check("midrst_busy",     busy, 0);
    check("midrst_done",     done, 0);
    check("midrst_im_addr",  im_addr, 0);
    check("midrst_im_wdata", im_wdata, 0);
    check("midrst_cpu_hold", cpu_hold, 1);
    exp_wr.delete();
    exp_done.delete();
    idle_cycles(2);
    @(negedge clk); reset = 1'b0;
    idle_cycles(2);
    check("post_reset_busy", busy, 0);
    $display("reset during write");

    check("final_wr_queue", exp_wr.size(), 0);
    check("final_done_queue", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
